mio_loader: RTL and testbench

Writable instruction memory with a serial program loader for the SoC. It replaces the fixed instruction ROM: it accepts a framed byte stream on a valid/ready interface and assembles it into 32-bit words in a 128×32 array. It holds the CPU while loading and releases it after a good frame. The CPU keeps the same two combinational read ports: instruction fetch and data-side read.

---
 rtl/mio_loader_pkg.sv | 15 +
 rtl/inst_ram.sv | 31 +++
 rtl/mio_loader.sv | 129 ++++++++++++
 tb/tb_mio_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_loader_pkg.sv
// Shared types and sizing for the writable instruction memory and its loader.
package mio_loader_pkg;

    localparam int DEPTH = 128;
    localparam int AW = 7;
    localparam int CNT_ZERO_MEANS_MAX = 128;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK
    } state_t;

endpackage

// File: rtl/inst_ram.sv
// DEPTH x 32 instruction array: one synchronous write port and two
// asynchronous read ports (fetch and data side).
module inst_ram
    import mio_loader_pkg::*;
#(
    parameter int RAM_DEPTH = DEPTH,
    parameter int RAM_AW = AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [RAM_AW-1:0] raddr_a,
    output logic [31:0]       rdata_a,
    input  logic [RAM_AW-1:0] raddr_b,
    output logic [31:0]       rdata_b
);

    // Contents survive clrn; the zero image is loaded at configuration.
    logic [31:0] mem [RAM_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mio_loader.sv
// Framed byte-stream program loader in front of the instruction RAM;
// holds the CPU until a frame with a good checksum has been written.
module mio_loader
    import mio_loader_pkg::*;
#(
    parameter int DEPTH = mio_loader_pkg::DEPTH,
    parameter int AW = mio_loader_pkg::AW
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] a,
    output logic [31:0] inst,
    input  logic [31:0] rom_a,
    output logic [31:0] d_f_rom,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  words_loaded
);

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [AW-1:0] addr;
    logic [7:0]    n_words;
    logic [7:0]    csum;
    logic [23:0]   shift;
    logic [7:0]    wl_q;
    logic          done_q;
    logic          err_q;
    logic          hold_q;

    logic          fire;
    logic          we;
    logic          last_word;
    logic [7:0]    cnt_n;
    logic          unused_addr_bits;

    assign rx_ready = (state != IDLE);
    assign busy = (state != IDLE);
    assign fire = rx_valid && rx_ready;

    // A start pulse overrides any byte presented in the same cycle.
    assign we = fire && !start && (state == DATA) && (byte_cnt == 2'd3);
    assign last_word = ((wl_q + 8'd1) == n_words);
    assign cnt_n = (rx_data == 8'd0) ? 8'(CNT_ZERO_MEANS_MAX) : rx_data;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            byte_cnt <= 2'd0;
            addr <= '0;
            n_words <= 8'd0;
            csum <= 8'd0;
            shift <= 24'd0;
            wl_q <= 8'd0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            hold_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state <= COUNT;
                byte_cnt <= 2'd0;
                addr <= '0;
                csum <= 8'd0;
                err_q <= 1'b0;
                hold_q <= 1'b1;
            end else if (fire) begin
                unique case (state)
                    COUNT: begin
                        n_words <= cnt_n;
                        csum <= rx_data;
                        addr <= '0;
                        wl_q <= 8'd0;
                        byte_cnt <= 2'd0;
                        state <= DATA;
                    end
                    DATA: begin
                        csum <= csum ^ rx_data;
                        shift <= {shift[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            addr <= addr + AW'(1);
                            wl_q <= wl_q + 8'd1;
                            if (last_word) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        err_q <= (rx_data != csum);
                        hold_q <= (rx_data != csum);
                        done_q <= 1'b1;
                        state <= IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cpu_hold = hold_q;
    assign done = done_q;
    assign err = err_q;
    assign words_loaded = wl_q;

    inst_ram #(
        .RAM_DEPTH(DEPTH),
        .RAM_AW(AW)
    ) u_ram (
        .clk(clk),
        .we(we),
        .waddr(addr),
        .wdata({shift, rx_data}),
        .raddr_a(a[AW+1:2]),
        .rdata_a(inst),
        .raddr_b(rom_a[AW+1:2]),
        .rdata_b(d_f_rom)
    );

    assign unused_addr_bits = ^{a[31:AW+2], a[1:0], rom_a[31:AW+2], rom_a[1:0]};

endmodule

// File: tb/tb_mio_loader.sv
// Randomized bench for mio_loader against a frame-level memory/status model.
module tb_mio_loader;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] inst;
    logic [31:0] rom_a = 32'd0;
    logic [31:0] d_f_rom;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [31:0] exp_mem [128];

    mio_loader dut (
        .clk(clk),
        .clrn(clrn),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .a(a),
        .inst(inst),
        .rom_a(rom_a),
        .d_f_rom(d_f_rom),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Frame image from a word list; the model records what lands in memory.
    function automatic void make_frame(input logic [31:0] w[$], input bit bad,
                                       output logic [7:0] f[$]);
        logic [7:0] cs;
        logic [7:0] b;
        f = {};
        cs = (w.size() == 128) ? 8'd0 : 8'(w.size());
        f.push_back(cs);
        foreach (w[i]) begin
            exp_mem[i] = w[i];
            for (int k = 3; k >= 0; k--) begin
                b = w[i][8*k +: 8];
                f.push_back(b);
                cs ^= b;
            end
        end
        f.push_back(bad ? ~cs : cs);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok;
        int g;
        g = $urandom_range(0, maxgap);
        repeat (g) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = rx_ready;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", 32'(rx_ready), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        chk("err_clr_on_start", 32'(err), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int maxgap,
                             input bit do_start, input bit exp_err,
                             input int exp_words, input int d0);
        if (do_start) pulse_start();
        foreach (f[i]) send_byte(f[i], maxgap);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_end", 32'(rx_ready), 32'd0);
        chk("err", 32'(err), 32'(exp_err));
        chk("cpu_hold", 32'(cpu_hold), 32'(exp_err));
        chk("words_loaded", 32'(words_loaded), 32'(exp_words));
        @(negedge clk);
        chk("done_low", 32'(done), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_mem();
        int j;
        for (int i = 0; i < 128; i++) begin
            j = 127 - i;
            a = ($urandom() & 32'hFFFF_FE00) | 32'(i << 2) | $urandom_range(0, 3);
            rom_a = ($urandom() & 32'hFFFF_FE00) | 32'(j << 2) | $urandom_range(0, 3);
            #1;
            chk($sformatf("inst[%0d]", i), inst, exp_mem[i]);
            chk($sformatf("d_f_rom[%0d]", j), d_f_rom, exp_mem[j]);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0]  f[$];
    logic [31:0] w[$];
    logic [31:0] w0;
    int d0;
    int n;
    bit bad;

    initial begin
        foreach (exp_mem[i]) exp_mem[i] = 32'd0;
        @(negedge clk);
        chk("init_hold", 32'(cpu_hold), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_ready", 32'(rx_ready), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_words", 32'(words_loaded), 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // bytes offered while idle go nowhere
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'($urandom());
            rx_valid = 1'b1;
            @(negedge clk);
            chk("idle_ready", 32'(rx_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        rx_valid = 1'b0;
        check_mem();
        @(negedge clk);

        f = '{8'h02, 8'h20, 8'h1D, 8'h10, 8'h00, 8'h23, 8'hBD, 8'hFF, 8'hF0, 8'hBE};
        exp_mem[0] = 32'h201D1000;
        exp_mem[1] = 32'h23BDFFF0;
        d0 = done_cnt;
        run_frame(f, 0, 1'b1, 1'b0, 2, d0);
        a = 32'h0;
        rom_a = 32'h4;
        #1;
        chk("good_inst0", inst, 32'h201D1000);
        chk("good_rom4", d_f_rom, 32'h23BDFFF0);
        a = 32'h4;
        #1;
        chk("good_inst4", inst, 32'h23BDFFF0);
        @(negedge clk);
        async_reset();
        check_mem();
        @(negedge clk);

        f[9] = 8'h00;
        d0 = done_cnt;
        run_frame(f, 0, 1'b1, 1'b1, 2, d0);
        check_mem();
        @(negedge clk);
        async_reset();

        w = {};
        for (int i = 0; i < 128; i++) w.push_back($urandom());
        make_frame(w, 1'b0, f);
        chk("full_count_byte", 32'(f[0]), 32'd0);
        d0 = done_cnt;
        run_frame(f, 1, 1'b1, 1'b0, 128, d0);
        a = 32'h1FC;
        #1;
        chk("full_word127", inst, w[127]);
        a = 32'h200;
        #1;
        chk("full_alias0", inst, w[0]);
        check_mem();
        @(negedge clk);

        // abort after count byte plus one full word, then reload
        d0 = done_cnt;
        w0 = $urandom();
        pulse_start();
        send_byte(8'h02, 0);
        for (int k = 3; k >= 0; k--) send_byte(w0[8*k +: 8], 0);
        exp_mem[0] = w0;
        rx_data = 8'h05;
        rx_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_valid = 1'b0;
        chk("restart_ready", 32'(rx_ready), 32'd1);
        w = '{32'hDEADBEEF};
        make_frame(w, 1'b0, f);
        run_frame(f, 0, 1'b0, 1'b0, 1, d0);
        a = 32'h0;
        #1;
        chk("restart_word0", inst, 32'hDEADBEEF);
        check_mem();
        @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            f = '{8'h02, 8'h20, 8'h1D, 8'h10, 8'h00, 8'h23, 8'hBD, 8'hFF, 8'hF0, 8'hBE};
            exp_mem[0] = 32'h201D1000;
            exp_mem[1] = 32'h23BDFFF0;
            d0 = done_cnt;
            run_frame(f, 10, 1'b1, 1'b0, 2, d0);
            check_mem();
            @(negedge clk);
        end

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 8);
            bad = 1'($urandom_range(0, 1));
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom());
            make_frame(w, bad, f);
            d0 = done_cnt;
            run_frame(f, 3, 1'b1, bad, n, d0);
            check_mem();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
